// File: rtl/serial_lu.sv
// Bit-serial logic unit: one result bit per clock, LSB first, over WIDTH cycles.
// Optional zero/parity flag outputs are built when SERIAL_LU_FLAGS_EN is defined.
`timescale 1ns/1ps

module serial_lu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
`ifdef SERIAL_LU_FLAGS_EN
  output logic             zero,
  output logic             parity,
`endif
  output logic [WIDTH-1:0] s
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] s_reg;
  logic [2:0]       op_reg;
  logic [CW-1:0]    cnt_reg;
  logic             bit_next;
  logic             last_bit;
  logic             accept;

  // A new request is only taken when no operation is in flight.
  assign accept   = start && (state_reg != BUSY);
  assign last_bit = (cnt_reg == CW'(WIDTH - 1));
  assign res_next = {bit_next, res_reg[WIDTH-1:1]};

  always_comb begin
    bit_next = 1'b0;
    case (op_reg)
      3'b000:  bit_next = a_reg[0] & b_reg[0];
      3'b001:  bit_next = ~(a_reg[0] & b_reg[0]);
      3'b010:  bit_next = a_reg[0] | b_reg[0];
      3'b011:  bit_next = ~(a_reg[0] | b_reg[0]);
      3'b100:  bit_next = a_reg[0] ^ b_reg[0];
      3'b101:  bit_next = ~(a_reg[0] ^ b_reg[0]);
      3'b110:  bit_next = ~a_reg[0];
      default: bit_next = b_reg[0];
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (last_bit) state_next = DONE;
      DONE:    state_next = start ? BUSY : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg   <= '0;
      b_reg   <= '0;
      res_reg <= '0;
      op_reg  <= '0;
      cnt_reg <= '0;
      s_reg   <= '0;
    end else if (accept) begin
      a_reg   <= a;
      b_reg   <= b;
      op_reg  <= op;
      res_reg <= '0;
      cnt_reg <= '0;
    end else if (state_reg == BUSY) begin
      a_reg   <= a_reg >> 1;
      b_reg   <= b_reg >> 1;
      res_reg <= res_next;
      cnt_reg <= cnt_reg + CW'(1);
      // The final bit goes straight into s so the result is valid in DONE.
      if (last_bit) s_reg <= res_next;
    end
  end

`ifdef SERIAL_LU_FLAGS_EN
  logic zero_reg;
  logic parity_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      zero_reg   <= 1'b1;
      parity_reg <= 1'b0;
    end else if (state_reg == BUSY && last_bit && !accept) begin
      zero_reg   <= (res_next == '0);
      parity_reg <= ^res_next;
    end
  end

  assign zero   = zero_reg;
  assign parity = parity_reg;
`endif

  assign busy = (state_reg == BUSY);
  assign done = (state_reg == DONE);
  assign s    = s_reg;

endmodule

// File: tb/tb_serial_lu.sv
// Directed bench for serial_lu (WIDTH=8) with a queue scoreboard of expected results.
// Flag checks are compiled in when SERIAL_LU_FLAGS_EN is defined.
`timescale 1ns/1ps

module tb_serial_lu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
`ifdef SERIAL_LU_FLAGS_EN
  logic         zero;
  logic         parity;
`endif

  int tests  = 0;
  int failed = 0;
  logic [W-1:0] q[$];

  serial_lu #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
`ifdef SERIAL_LU_FLAGS_EN
    .zero   (zero),
    .parity (parity),
`endif
    .s      (s)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] av,
                                         input logic [W-1:0] bv);
    case (o)
      3'd0:    return av & bv;
      3'd1:    return ~(av & bv);
      3'd2:    return av | bv;
      3'd3:    return ~(av | bv);
      3'd4:    return av ^ bv;
      3'd5:    return ~(av ^ bv);
      3'd6:    return ~av;
      default: return bv;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one start pulse; operands are scrambled afterwards to prove they were captured.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input bit push);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    if (push) q.push_back(model(o, av, bv));
    tick();
    start = 1'b0;
    op    = 3'($urandom);
    a     = W'($urandom);
    b     = W'($urandom);
  endtask

  task automatic wait_done(input string tag, input int lat);
    int n;
    logic [W-1:0] exp;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    if (q.size() == 0) begin
      chk({tag, "_queue_nonempty"}, 32'd0, 32'd1);
      exp = '0;
    end else begin
      exp = q.pop_front();
    end
    chk({tag, "_s"}, 32'(s), 32'(exp));
`ifdef SERIAL_LU_FLAGS_EN
    chk({tag, "_zero"}, {31'd0, zero}, {31'd0, (exp == '0)});
    chk({tag, "_parity"}, {31'd0, parity}, {31'd0, ^exp});
`endif
    $display("[TB] %s: s=%h expected=%h latency=%0d", tag, s, exp, n);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_s", 32'(s), 32'd0);
`ifdef SERIAL_LU_FLAGS_EN
    chk("reset_zero", {31'd0, zero}, 32'd1);
    chk("reset_parity", {31'd0, parity}, 32'd0);
`endif

    // Reset wins over a simultaneous start.
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk("reset_prio_busy", {31'd0, busy}, 32'd0);

    // AND F0/CC: busy for exactly WIDTH cycles, then a single done.
    issue(3'b000, 8'hF0, 8'hCC, 1'b1);
    for (int i = 0; i < W; i++) begin
      chk($sformatf("and_busy_%0d", i), {30'd0, busy, done}, 32'd2);
      tick();
    end
    wait_done("and", 0);
    tick();
    chk("and_done_pulse", {31'd0, done}, 32'd0);
    chk("and_s_hold", 32'(s), 32'hC0);

    // Back-to-back: NOR then XOR started during DONE.
    issue(3'b011, 8'hF0, 8'hCC, 1'b1);
    wait_done("nor", W);
    issue(3'b100, 8'hF0, 8'hCC, 1'b1);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done("xor", W);

    // Start while BUSY is ignored.
    tick();
    issue(3'b110, 8'h0F, 8'h00, 1'b1);
    tick();
    tick();
    issue(3'b111, 8'hAA, 8'h55, 1'b0);
    wait_done("nota", W - 3);
    tick();
    chk("nota_idle", {30'd0, busy, done}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("nota_no_extra_done_%0d", i), {31'd0, done}, 32'd0);
    end
    chk("nota_s_hold", 32'(s), 32'hF0);

    // Reset four cycles into BUSY aborts without a done.
    issue(3'b000, 8'h12, 8'h34, 1'b0);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_state", {30'd0, busy, done}, 32'd0);
    chk("abort_s", 32'(s), 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("abort_no_done_%0d", i), {31'd0, done}, 32'd0);
    end

    // Flag-oriented vectors, then every opcode with random operands.
    issue(3'b000, 8'h0F, 8'hF0, 1'b1);
    wait_done("and_zero", W);
    issue(3'b101, 8'h00, 8'h01, 1'b1);
    wait_done("xnor_fe", W);
    for (int o = 0; o < 8; o++) begin
      issue(3'(o), W'($urandom), W'($urandom), 1'b1);
      wait_done($sformatf("rand_op%0d", o), W);
    end

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
